mmio_gpio: RTL and testbench

Parametrised memory-mapped GPIO peripheral on the picorv32 native memory bus. It is the successor to the single fixed LED register and provides:
- N pins with per-pin direction control
- synchronised inputs
- rising-edge interrupt status with write-1-to-clear
- a per-pin hardware blink mode driven by a programmable prescaler

It decodes its own 32-byte window and drives mem_ready/mem_rdata into the SoC read mux.

---
 rtl/mmio_gpio_pkg.sv | 29 ++
 rtl/mmio_gpio_sync_edge.sv | 31 +++
 rtl/mmio_gpio.sv | 127 ++++++++++++
 tb/tb_mmio_gpio.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_gpio_pkg.sv
// rtl/mmio_gpio_pkg.sv - shared constants and helpers for the mmio_gpio peripheral
package mmio_gpio_pkg;

    // Word offsets within the 32-byte window (mem_addr[4:2])
    localparam logic [2:0] OFF_OUT       = 3'd0;
    localparam logic [2:0] OFF_DIR       = 3'd1;
    localparam logic [2:0] OFF_IN        = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN    = 3'd3;
    localparam logic [2:0] OFF_IRQ_STAT  = 3'd4;
    localparam logic [2:0] OFF_BLINK_EN  = 3'd5;
    localparam logic [2:0] OFF_BLINK_DIV = 3'd6;
    localparam logic [2:0] OFF_ID        = 3'd7;

    localparam logic [15:0] ID_MAGIC   = 16'h4750;
    localparam logic [7:0]  ID_VERSION = 8'h01;

    // Merge write data into a register image, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_gpio_sync_edge.sv
// rtl/mmio_gpio_sync_edge.sv - multi-stage input synchroniser with rising-edge detect
module gpio_sync_edge #(
    parameter int N      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] sync_in,
    output logic [N-1:0] rise
);

    logic [N-1:0] stage [STAGES];
    logic [N-1:0] prev;

    // Shift the raw pins through the chain; prev holds last cycle's synchronised value
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s < STAGES; s++) stage[s] <= '0;
            prev <= '0;
        end else begin
            stage[0] <= async_in;
            for (int s = 1; s < STAGES; s++) stage[s] <= stage[s-1];
            prev <= stage[STAGES-1];
        end
    end

    assign sync_in = stage[STAGES-1];
    assign rise    = sync_in & ~prev;

endmodule

// File: rtl/mmio_gpio.sv
// rtl/mmio_gpio.sv - memory-mapped GPIO with direction, edge IRQ and blink prescaler
module mmio_gpio
    import mmio_gpio_pkg::*;
#(
    parameter int          NUM_PINS    = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          SYNC_STAGES = 2,
    parameter int          DIV_WIDTH   = 24
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    logic [NUM_PINS-1:0]  out_r, dir_r, irq_en_r, irq_stat_r, blink_en_r;
    logic [DIV_WIDTH-1:0] blink_div_r, cnt;
    logic                 phase;
    logic [NUM_PINS-1:0]  sync_in, rise, w1c;
    logic [2:0]           off;
    logic                 hit, wr;
    logic [31:0]          rdata_mux;
    logic [31:0]          out_w, dir_w, ien_w, ben_w, div_w, clr_w;
    logic                 unused_bits;

    gpio_sync_edge #(
        .N      (NUM_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (gpio_in),
        .sync_in  (sync_in),
        .rise     (rise)
    );

    // The !mem_ready term keeps a request held through its ready cycle from being taken twice
    assign off = mem_addr[4:2];
    assign hit = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]) && !mem_ready;
    assign wr  = hit && (mem_wstrb != 4'b0000);

    assign out_w = apply_wstrb(32'(out_r),       mem_wdata, mem_wstrb);
    assign dir_w = apply_wstrb(32'(dir_r),       mem_wdata, mem_wstrb);
    assign ien_w = apply_wstrb(32'(irq_en_r),    mem_wdata, mem_wstrb);
    assign ben_w = apply_wstrb(32'(blink_en_r),  mem_wdata, mem_wstrb);
    assign div_w = apply_wstrb(32'(blink_div_r), mem_wdata, mem_wstrb);
    assign clr_w = apply_wstrb(32'h0,            mem_wdata, mem_wstrb);
    assign w1c   = (wr && off == OFF_IRQ_STAT) ? clr_w[NUM_PINS-1:0] : '0;

    assign unused_bits = ^{mem_addr[1:0], out_w, dir_w, ien_w, ben_w, div_w, clr_w};

    // Read data selection by word offset; unimplemented bits are zero-extended
    always_comb begin
        rdata_mux = '0;
        case (off)
            OFF_OUT:       rdata_mux = 32'(out_r);
            OFF_DIR:       rdata_mux = 32'(dir_r);
            OFF_IN:        rdata_mux = 32'(sync_in);
            OFF_IRQ_EN:    rdata_mux = 32'(irq_en_r);
            OFF_IRQ_STAT:  rdata_mux = 32'(irq_stat_r);
            OFF_BLINK_EN:  rdata_mux = 32'(blink_en_r);
            OFF_BLINK_DIV: rdata_mux = 32'(blink_div_r);
            OFF_ID:        rdata_mux = {ID_MAGIC, 8'(NUM_PINS), ID_VERSION};
            default:       rdata_mux = '0;
        endcase
    end

    // Register file, bus response, IRQ status/output and registered pin drivers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r       <= '0;
            dir_r       <= '0;
            irq_en_r    <= '0;
            irq_stat_r  <= '0;
            blink_en_r  <= '0;
            blink_div_r <= '0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            gpio_out    <= '0;
            gpio_oe     <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr) begin
                case (off)
                    OFF_OUT:       out_r       <= out_w[NUM_PINS-1:0];
                    OFF_DIR:       dir_r       <= dir_w[NUM_PINS-1:0];
                    OFF_IRQ_EN:    irq_en_r    <= ien_w[NUM_PINS-1:0];
                    OFF_BLINK_EN:  blink_en_r  <= ben_w[NUM_PINS-1:0];
                    OFF_BLINK_DIV: blink_div_r <= div_w[DIV_WIDTH-1:0];
                    default: ;
                endcase
            end
            // A rise in the same cycle as its W1C wins: the new event must not be lost
            irq_stat_r <= (irq_stat_r & ~w1c) | rise;
            irq        <= |(irq_stat_r & irq_en_r);
            mem_ready  <= hit;
            mem_rdata  <= hit ? rdata_mux : '0;
            gpio_out   <= (blink_en_r & {NUM_PINS{phase}}) | (out_r & ~blink_en_r);
            gpio_oe    <= dir_r;
        end
    end

    // Blink prescaler; any BLINK_DIV write restarts the count and phase
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wr && off == OFF_BLINK_DIV) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == blink_div_r) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb/tb_mmio_gpio.sv - directed self-checking bench for mmio_gpio
module tb_mmio_gpio;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  gpio_in;
    logic [3:0]  gpio_out;
    logic [3:0]  gpio_oe;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        rdy;

    mmio_gpio dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request on a falling edge, sample the response one full cycle later
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata,
                            output logic ready);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        @(negedge clk);
        ready     = mem_ready;
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic wr_reg(input string tag, input logic [4:0] offs, input logic [31:0] data);
        logic [31:0] d;
        logic        r;
        bus_xfer(BASE | 32'(offs), data, 4'b1111, d, r);
        check(tag, 32'(r), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] offs, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        bus_xfer(BASE | 32'(offs), 32'h0, 4'b0000, d, r);
        check({tag, "_rdy"}, 32'(r), 32'd1);
        check(tag, d, exp);
    endtask

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        gpio_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;

        // ID read: ready exactly one cycle after valid, and only for one cycle
        bus_xfer(BASE + 32'h1C, 32'h0, 4'b0000, rd, rdy);
        check("id_rdy", 32'(rdy), 32'd1);
        check("id_data", rd, 32'h4750_0401);
        @(negedge clk);
        check("id_rdy_drop", 32'(mem_ready), 32'd0);

        // Out-of-window read never acknowledged
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h20;
        mem_wstrb = 4'b0000;
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_ready) rdy = 1'b1;
        end
        mem_valid = 1'b0;
        check("miss_rdy", 32'(rdy), 32'd0);

        // Byte-lane write of OUT, then DIR
        bus_xfer(BASE + 32'h00, 32'hFFFF_FFFA, 4'b0001, rd, rdy);
        check("out_wr_rdy", 32'(rdy), 32'd1);
        @(negedge clk);
        check("gpio_out_a", 32'(gpio_out), 32'hA);
        wr_reg("dir_wr_rdy", 5'h04, 32'h0000_000F);
        @(negedge clk);
        check("gpio_oe_f", 32'(gpio_oe), 32'hF);
        rd_chk("out_rd", 5'h00, 32'h0000_000A);
        rd_chk("dir_rd", 5'h04, 32'h0000_000F);
        wr_reg("in_wr_rdy", 5'h08, 32'hFFFF_FFFF);
        rd_chk("in_rd", 5'h08, 32'h0);

        // Blink pin 0 with BLINK_DIV=3: phase 0 for 4 cycles, then 1 for 4, ...
        wr_reg("ben_wr", 5'h14, 32'h1);
        wr_reg("div_wr", 5'h18, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", k), 32'(gpio_out), {28'h0, 3'b101, 1'(((k - 1) / 4) % 2)});
        end
        rd_chk("div_rd", 5'h18, 32'h3);
        repeat (2) @(negedge clk);
        // Rewrite restarts at phase 0 even if phase is currently 1
        wr_reg("div_rewr", 5'h18, 32'h3);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("reblink_%0d", k), 32'(gpio_out), {28'h0, 3'b101, 1'(((k - 1) / 4) % 2)});
        end
        wr_reg("ben_off", 5'h14, 32'h0);

        // Rising-edge IRQ on pin 2
        wr_reg("ien_wr", 5'h0C, 32'h4);
        @(negedge clk);
        gpio_in = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) check("irq_c3", 32'(irq), 32'd0);
            if (k == 4) check("irq_c4", 32'(irq), 32'd1);
        end
        rd_chk("stat_4", 5'h10, 32'h4);
        rd_chk("in_4", 5'h08, 32'h4);
        gpio_in = 4'b0110;
        repeat (5) @(negedge clk);
        rd_chk("stat_6", 5'h10, 32'h6);
        check("irq_still", 32'(irq), 32'd1);
        wr_reg("w1c_4", 5'h10, 32'h4);
        @(negedge clk);
        check("irq_clr", 32'(irq), 32'd0);
        rd_chk("stat_2", 5'h10, 32'h2);

        // Collision: set bit 0, drop the pin, then a new rise lands with its W1C
        gpio_in = 4'b0111;
        repeat (5) @(negedge clk);
        gpio_in = 4'b0110;
        repeat (4) @(negedge clk);
        rd_chk("stat_3", 5'h10, 32'h3);
        gpio_in = 4'b0111;
        @(negedge clk);
        bus_xfer(BASE + 32'h10, 32'h1, 4'b0001, rd, rdy);
        check("coll_rdy", 32'(rdy), 32'd1);
        rd_chk("coll_stat", 5'h10, 32'h3);
        wr_reg("w1c_3", 5'h10, 32'h3);
        rd_chk("stat_0", 5'h10, 32'h0);

        // Reset during the ready cycle of a write
        gpio_in = 4'b0000;
        repeat (4) @(negedge clk);
        wr_reg("ben_pre", 5'h14, 32'h0);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h00;
        mem_wdata = 32'h5;
        mem_wstrb = 4'b1111;
        @(negedge clk);
        check("pre_rst_rdy", 32'(mem_ready), 32'd1);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(negedge clk);
        check("mid_rst_rdy", 32'(mem_ready), 32'd0);
        check("mid_rst_out", 32'(gpio_out), 32'h0);
        check("mid_rst_oe", 32'(gpio_oe), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_rdata", mem_rdata, 32'h0);
        resetn = 1'b1;
        rd_chk("post_rst_out", 5'h00, 32'h0);
        rd_chk("post_rst_dir", 5'h04, 32'h0);
        rd_chk("post_rst_div", 5'h18, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
